// File: rtl/pe.sv
// FP32 multiply-accumulate processing element for the systolic array.
// Each clock: acc <= acc + a*b, truncating rounding, subnormals flushed to zero.
module pe (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PE_a,
  input  logic [31:0] PE_b,
  output logic [31:0] PE_r
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Decoded fields of both multiplier operands
  logic        aSign, bSign;
  logic [7:0]  aExp, bExp;
  logic [22:0] aFrac, bFrac;
  logic        aZero, bZero, aInf, bInf, aNan, bNan;
  logic [23:0] aSig, bSig;

  assign aSign = PE_a[31];
  assign aExp  = PE_a[30:23];
  assign aFrac = PE_a[22:0];
  assign bSign = PE_b[31];
  assign bExp  = PE_b[30:23];
  assign bFrac = PE_b[22:0];

  assign aZero = (aExp == 8'h00);
  assign bZero = (bExp == 8'h00);
  assign aInf  = (aExp == 8'hFF) && (aFrac == 23'd0);
  assign bInf  = (bExp == 8'hFF) && (bFrac == 23'd0);
  assign aNan  = (aExp == 8'hFF) && (aFrac != 23'd0);
  assign bNan  = (bExp == 8'hFF) && (bFrac != 23'd0);
  assign aSig  = {1'b1, aFrac};
  assign bSig  = {1'b1, bFrac};

  logic [47:0]       sigProd;
  logic              prodSign;
  logic signed [9:0] prodExp;
  logic [22:0]       prodFrac;
  logic [31:0]       prod;

  // Multiplier: product lies in [1,4), so a single right shift normalises it
  always_comb begin
    sigProd  = 48'(aSig) * 48'(bSig);
    prodSign = aSign ^ bSign;
    prodExp  = $signed({2'b00, aExp}) + $signed({2'b00, bExp}) - 10'sd127;
    prodFrac = sigProd[47] ? sigProd[46:24] : sigProd[45:23];
    if (sigProd[47]) begin
      prodExp = prodExp + 10'sd1;
    end
    if (aNan || bNan) begin
      prod = QNAN;
    end else if ((aInf && bZero) || (bInf && aZero)) begin
      prod = QNAN;
    end else if (aInf || bInf) begin
      prod = {prodSign, 8'hFF, 23'd0};
    end else if (aZero || bZero) begin
      prod = {prodSign, 31'd0};
    end else if (prodExp >= 10'sd255) begin
      prod = {prodSign, 8'hFF, 23'd0};
    end else if (prodExp <= 10'sd0) begin
      prod = {prodSign, 31'd0};
    end else begin
      prod = {prodSign, prodExp[7:0], prodFrac};
    end
  end

  logic [31:0] acc_q, acc_d;

  // Decoded fields of the adder operands (accumulator and product)
  logic        accSign, pSign;
  logic [7:0]  accExp, pExp;
  logic        accZero, pZero, accInf, pInf, accNan, pNan;

  assign accSign = acc_q[31];
  assign accExp  = acc_q[30:23];
  assign pSign   = prod[31];
  assign pExp    = prod[30:23];
  assign accZero = (accExp == 8'h00);
  assign pZero   = (pExp == 8'h00);
  assign accInf  = (accExp == 8'hFF) && (acc_q[22:0] == 23'd0);
  assign pInf    = (pExp == 8'hFF) && (prod[22:0] == 23'd0);
  assign accNan  = (accExp == 8'hFF) && (acc_q[22:0] != 23'd0);
  assign pNan    = (pExp == 8'hFF) && (prod[22:0] != 23'd0);

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

  logic              swapOps, effSub, sticky;
  logic              bigSign;
  logic [7:0]        bigExp, smallExp, expDiff;
  logic [23:0]       bigSig, smallSig;
  logic [26:0]       bigExt, smallExt, aligned, norm;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic signed [9:0] sumExp;

  // Adder: three extra bits (guard, round, sticky) keep truncation exact
  always_comb begin
    swapOps  = prod[30:0] > acc_q[30:0];
    effSub   = accSign ^ pSign;
    bigSign  = swapOps ? pSign : accSign;
    bigExp   = swapOps ? pExp : accExp;
    smallExp = swapOps ? accExp : pExp;
    bigSig   = swapOps ? {1'b1, prod[22:0]} : {1'b1, acc_q[22:0]};
    smallSig = swapOps ? {1'b1, acc_q[22:0]} : {1'b1, prod[22:0]};
    expDiff  = bigExp - smallExp;
    bigExt   = {bigSig, 3'b000};
    smallExt = {smallSig, 3'b000};
    if (expDiff >= 8'd27) begin
      sticky  = 1'b1;
      aligned = 27'd1;
    end else begin
      sticky  = |(smallExt & ~({27{1'b1}} << expDiff));
      aligned = smallExt >> expDiff;
      aligned[0] = aligned[0] | sticky;
    end
    sum    = effSub ? ({1'b0, bigExt} - {1'b0, aligned})
                    : ({1'b0, bigExt} + {1'b0, aligned});
    sumExp = $signed({2'b00, bigExp});
    lz     = 5'd0;
    if (sum[27]) begin
      norm   = {sum[27:2], sum[1] | sum[0]};
      sumExp = sumExp + 10'sd1;
    end else begin
      lz     = lzc27(sum[26:0]);
      norm   = sum[26:0] << lz;
      sumExp = sumExp - $signed({5'b00000, lz});
    end

    if (accNan || pNan) begin
      acc_d = QNAN;
    end else if (accInf && pInf && effSub) begin
      acc_d = QNAN;
    end else if (accInf) begin
      acc_d = acc_q;
    end else if (pInf) begin
      acc_d = prod;
    end else if (accZero && pZero) begin
      acc_d = {accSign & pSign, 31'd0};
    end else if (pZero) begin
      acc_d = acc_q;
    end else if (accZero) begin
      acc_d = prod;
    end else if (sum == 28'd0) begin
      acc_d = 32'h0000_0000;
    end else if (sumExp >= 10'sd255) begin
      acc_d = {bigSign, 8'hFF, 23'd0};
    end else if (sumExp <= 10'sd0) begin
      acc_d = {bigSign, 31'd0};
    end else begin
      acc_d = {bigSign, sumExp[7:0], norm[25:3]};
    end
  end

  // Bits below the truncation point are intentionally dropped
  logic unusedBits;
  assign unusedBits = ^{sigProd[22:0], norm[26], norm[2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 32'h0000_0000;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign PE_r = acc_q;

endmodule

// File: tb/tb_pe.sv
// Directed self-checking bench for the FP32 MAC processing element.
module tb_pe;

  logic        clk;
  logic        rst;
  logic [31:0] PE_a;
  logic [31:0] PE_b;
  logic [31:0] PE_r;

  int checkCount = 0;
  int failCount  = 0;

  pe dut (
    .clk  (clk),
    .rst  (rst),
    .PE_a (PE_a),
    .PE_b (PE_b),
    .PE_r (PE_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic r);
    PE_a = a;
    PE_b = b;
    rst  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    applyStimulus(32'h4000_0000, 32'h4100_0000, 1'b1);
    checkCount++;
    if (PE_r !== 32'h0000_0000) begin
      failCount++;
      $display("[TB] FAIL reset_clear: got %h expected 00000000", PE_r);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(32'h0, 32'h0, 1'b0);
      checkCount++;
      if (PE_r !== 32'h0000_0000) begin
        failCount++;
        $display("[TB] FAIL zero_hold[%0d]: got %h expected 00000000", i, PE_r);
      end
    end
  endtask

  task automatic test_accumulate;
    logic [31:0] expected [5] = '{32'h4180_0000, 32'h4200_0000, 32'h4240_0000,
                                  32'h4280_0000, 32'h42A0_0000};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(32'h4000_0000, 32'h4100_0000, 1'b0);
      checkCount++;
      if (PE_r !== expected[i]) begin
        failCount++;
        $display("[TB] FAIL accum_2x8[%0d]: got %h expected %h", i, PE_r, expected[i]);
      end
    end
  endtask

  task automatic test_continue;
    logic [31:0] expected [5] = '{32'h42E0_0000, 32'h4310_0000, 32'h4330_0000,
                                  32'h4350_0000, 32'h4370_0000};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(32'h4080_0000, 32'h4100_0000, 1'b0);
      checkCount++;
      if (PE_r !== expected[i]) begin
        failCount++;
        $display("[TB] FAIL accum_4x8[%0d]: got %h expected %h", i, PE_r, expected[i]);
      end
    end
  endtask

  task automatic test_mid_reset;
    applyStimulus(32'h4100_0000, 32'h4100_0000, 1'b1);
    checkCount++;
    if (PE_r !== 32'h0000_0000) begin
      failCount++;
      $display("[TB] FAIL mid_reset: got %h expected 00000000", PE_r);
    end
    applyStimulus(32'h4100_0000, 32'h4100_0000, 1'b0);
    checkCount++;
    if (PE_r !== 32'h4280_0000) begin
      failCount++;
      $display("[TB] FAIL restart_8x8: got %h expected 42800000", PE_r);
    end
  endtask

  task automatic test_cancel;
    applyStimulus(32'h0, 32'h0, 1'b1);
    applyStimulus(32'h4000_0000, 32'h4100_0000, 1'b0);
    checkCount++;
    if (PE_r !== 32'h4180_0000) begin
      failCount++;
      $display("[TB] FAIL cancel_setup: got %h expected 41800000", PE_r);
    end
    applyStimulus(32'hC000_0000, 32'h4100_0000, 1'b0);
    checkCount++;
    if (PE_r !== 32'h0000_0000) begin
      failCount++;
      $display("[TB] FAIL cancel_to_zero: got %h expected 00000000", PE_r);
    end
  endtask

  task automatic test_truncation;
    // 1.5 * (1 + 2^-23) = 1.5 + 1.5 ulp, truncates to 1.5 + 1 ulp
    applyStimulus(32'h0, 32'h0, 1'b1);
    applyStimulus(32'h3FC0_0000, 32'h3F80_0001, 1'b0);
    checkCount++;
    if (PE_r !== 32'h3FC0_0001) begin
      failCount++;
      $display("[TB] FAIL mul_truncate: got %h expected 3fc00001", PE_r);
    end
    applyStimulus(32'h0, 32'h0, 1'b1);
    applyStimulus(32'h3F80_0000, 32'h3F80_0000, 1'b0);
    applyStimulus(32'h3FC0_0000, 32'h3380_0000, 1'b0);
    checkCount++;
    if (PE_r !== 32'h3F80_0000) begin
      failCount++;
      $display("[TB] FAIL add_truncate: got %h expected 3f800000", PE_r);
    end
    applyStimulus(32'h3FC0_0000, 32'h3FC0_0000, 1'b1);
    applyStimulus(32'h3FC0_0000, 32'h3FC0_0000, 1'b0);
    checkCount++;
    if (PE_r !== 32'h4010_0000) begin
      failCount++;
      $display("[TB] FAIL mul_norm_shift: got %h expected 40100000", PE_r);
    end
  endtask

  task automatic test_subtract_normalize;
    applyStimulus(32'h0, 32'h0, 1'b1);
    applyStimulus(32'h3F80_0000, 32'h3F80_0000, 1'b0);
    applyStimulus(32'hBF40_0000, 32'h3F80_0000, 1'b0);
    checkCount++;
    if (PE_r !== 32'h3E80_0000) begin
      failCount++;
      $display("[TB] FAIL sub_renorm: got %h expected 3e800000", PE_r);
    end
  endtask

  task automatic test_overflow;
    applyStimulus(32'h0, 32'h0, 1'b1);
    applyStimulus(32'h7F00_0000, 32'h4000_0000, 1'b0);
    checkCount++;
    if (PE_r !== 32'h7F80_0000) begin
      failCount++;
      $display("[TB] FAIL mul_overflow: got %h expected 7f800000", PE_r);
    end
    applyStimulus(32'h3F80_0000, 32'h3F80_0000, 1'b0);
    checkCount++;
    if (PE_r !== 32'h7F80_0000) begin
      failCount++;
      $display("[TB] FAIL inf_sticky: got %h expected 7f800000", PE_r);
    end
    applyStimulus(32'hFF80_0000, 32'h3F80_0000, 1'b0);
    checkCount++;
    if (PE_r !== 32'h7FC0_0000) begin
      failCount++;
      $display("[TB] FAIL inf_minus_inf: got %h expected 7fc00000", PE_r);
    end
  endtask

  task automatic test_underflow;
    applyStimulus(32'h0, 32'h0, 1'b1);
    applyStimulus(32'h2000_0000, 32'h2000_0000, 1'b0);
    checkCount++;
    if (PE_r !== 32'h0080_0000) begin
      failCount++;
      $display("[TB] FAIL min_normal: got %h expected 00800000", PE_r);
    end
    applyStimulus(32'hBFC0_0000, 32'h0080_0000, 1'b0);
    checkCount++;
    if (PE_r !== 32'h8000_0000) begin
      failCount++;
      $display("[TB] FAIL add_underflow: got %h expected 80000000", PE_r);
    end
    applyStimulus(32'h8000_0000, 32'h3F80_0000, 1'b0);
    checkCount++;
    if (PE_r !== 32'h8000_0000) begin
      failCount++;
      $display("[TB] FAIL neg_zero_sum: got %h expected 80000000", PE_r);
    end
    applyStimulus(32'h0, 32'h0, 1'b1);
    applyStimulus(32'h3F80_0000, 32'h3F80_0000, 1'b0);
    applyStimulus(32'h0D80_0000, 32'h0D80_0000, 1'b0);
    checkCount++;
    if (PE_r !== 32'h3F80_0000) begin
      failCount++;
      $display("[TB] FAIL mul_underflow: got %h expected 3f800000", PE_r);
    end
  endtask

  task automatic test_nan;
    applyStimulus(32'h0, 32'h0, 1'b1);
    applyStimulus(32'h7F80_0001, 32'h3F80_0000, 1'b0);
    checkCount++;
    if (PE_r !== 32'h7FC0_0000) begin
      failCount++;
      $display("[TB] FAIL nan_operand: got %h expected 7fc00000", PE_r);
    end
  endtask

  task automatic test_inf_times_zero;
    applyStimulus(32'h0, 32'h0, 1'b1);
    applyStimulus(32'h7F80_0000, 32'h0000_0000, 1'b0);
    checkCount++;
    if (PE_r !== 32'h7FC0_0000) begin
      failCount++;
      $display("[TB] FAIL inf_x_zero: got %h expected 7fc00000", PE_r);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h4000_0000, 32'h4100_0000, 1'b0);
      checkCount++;
      if (PE_r !== 32'h7FC0_0000) begin
        failCount++;
        $display("[TB] FAIL nan_sticky[%0d]: got %h expected 7fc00000", i, PE_r);
      end
    end
    applyStimulus(32'h0, 32'h0, 1'b1);
    checkCount++;
    if (PE_r !== 32'h0000_0000) begin
      failCount++;
      $display("[TB] FAIL nan_reset: got %h expected 00000000", PE_r);
    end
  endtask

  initial begin
    rst  = 1'b1;
    PE_a = 32'h0;
    PE_b = 32'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_accumulate();
    test_continue();
    test_mid_reset();
    test_cancel();
    test_truncation();
    test_subtract_normalize();
    test_overflow();
    test_underflow();
    test_nan();
    test_inf_times_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
